// File: rtl/demux_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : demux_ctrl_pkg
// Brief   : Shared types and constants for the 16-way dispatch controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package demux_ctrl_pkg;

  localparam int N     = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  function automatic logic [N-1:0] onehot_sel(input logic [SEL_W-1:0] s);
    logic [N-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick16.sv
//------------------------------------------------------------------------------
// Module  : rr_pick16
// Brief   : Combinational round-robin search: first set request at or above
//           ptr, wrapping 15 -> 0.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick16
  import demux_ctrl_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Offset index wraps naturally in SEL_W bits, giving the circular order.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + SEL_W'(i);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_dispatch_ctrl.sv
//------------------------------------------------------------------------------
// Module  : demux_dispatch_ctrl
// Brief   : Accepts one word, round-robin grants it to a ready and enabled
//           destination, holds it until that destination takes it.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux_dispatch_ctrl #(
  parameter int W = 8,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic [N-1:0] dst_ready,
  input  logic [N-1:0] dst_en,
  output logic [N-1:0] y_valid,
  output logic [W-1:0] y_data,
  output logic [3:0]   sel,
  output logic [15:0]  xfer_cnt
);

  import demux_ctrl_pkg::*;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [W-1:0]     hold_q, hold_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [N-1:0]     eligible;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  assign eligible = dst_ready & dst_en;

  rr_pick16 u_pick (
    .req     (eligible),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // The grant is fixed once in SEND; only dst_ready[sel] matters there,
  // so a destination losing its enable mid-transfer does not redirect data.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          hold_d  = in_data;
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (dst_ready[sel_q]) begin
          ptr_d   = sel_q + SEL_W'(1);
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready = (state_q == ST_IDLE);
  assign y_valid  = (state_q == ST_SEND) ? onehot_sel(sel_q) : '0;
  assign y_data   = hold_q;
  assign sel      = sel_q;
  assign xfer_cnt = cnt_q;

endmodule

`default_nettype wire

// File: doc/demux_dispatch_ctrl.md
DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 Parameter W, default 8, data word width in bits.
REQ-002 Parameter N, fixed 16, number of destinations; select width is 4.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  source offers a word on in_data.
REQ-006 in_data  input  W  word to dispatch.
REQ-007 in_ready  output  1  controller accepts a word this cycle.
REQ-008 dst_ready  input  16  per-destination ready; bit k means destination k can take a word.
REQ-009 dst_en  input  16  per-destination enable mask; a disabled destination is never granted.
REQ-010 y_valid  output  16  one-hot valid toward destination sel; all zero when not sending.
REQ-011 y_data  output  W  held word, driven to all destinations.
REQ-012 sel  output  4  index of the granted destination (demux select, bit 3 = s3 ... bit 0 = s0).
REQ-013 xfer_cnt  output  16  count of completed transfers.

Function
REQ-014 FSM states SHALL be IDLE, ARB, SEND.
REQ-015 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-016 On accept: latch in_data into the hold register; IDLE->ARB.
REQ-017 Eligible set = dst_ready & dst_en.
REQ-018 ARB: if the eligible set is non-zero, grant the first eligible index at or above ptr, wrapping 15->0; register it into sel; ARB->SEND.
REQ-019 ARB with an empty eligible set: remain in ARB with the word held; no data loss; no timeout.
REQ-020 SEND: y_valid = one-hot(sel); y_data = hold register; stable until transfer.
REQ-021 Transfer = SEND & dst_ready[sel]; on transfer: SEND->IDLE, ptr <= sel+1 mod 16, xfer_cnt += 1.
REQ-022 Once granted, the grant SHALL NOT change in SEND, even if dst_en[sel] drops.
REQ-023 xfer_cnt SHALL wrap 0xFFFF->0x0000.
REQ-024 Minimum latency: accept in cycle t, ARB in t+1, y_valid high in t+2; one word per 3 cycles maximum throughput.
REQ-025 y_valid SHALL be all zero in IDLE and ARB; at most one bit set at any time.
REQ-026 in_valid dropping while not in IDLE SHALL have no effect.

Reset
REQ-027 While rst=1, regardless of clk: state=IDLE, ptr=0, sel=0, hold=0, xfer_cnt=0, y_valid=0, in_ready=1 after release.
REQ-028 Reset in ARB or SEND SHALL abandon the held word, with no transfer counted.

Structure
REQ-029 Package demux_ctrl_pkg SHALL hold the FSM state typedef, N=16, SEL_W=4.
REQ-030 Round-robin search SHALL be a sub-module rr_pick16 with inputs req[15:0] and ptr[3:0], and outputs gnt_idx[3:0] and any. It SHALL be combinational and instantiated once.

Verification
REQ-031 Reset, then in_data=0xA5, all ready/en=1 -> sel=0, y_valid=0x0001 at t+2, y_data=0xA5, xfer_cnt=1, ptr=1.
REQ-032 Sixteen back-to-back words, all ready -> sel sequence 0,1,...,15 then 0; xfer_cnt=16.
REQ-033 ptr=14, dst_ready=0x0009 -> sel=0 (wrap), then next word with same ready gives sel=3.
REQ-034 dst_en=0x0000 while holding 0x3C -> stays in ARB, in_ready=0; set dst_en=0x0100 -> sel=8, y_valid=0x0100.
REQ-035 In SEND with sel=5, hold dst_ready[5]=0 for 4 cycles -> y_valid=0x0020 and y_data stable; xfer completes on the ready cycle.
REQ-036 Assert rst asynchronously in SEND -> y_valid=0 immediately, xfer_cnt=0, ptr=0, in_ready=1 after release.
